// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, deserialises an MSB-first
// payload, checks a trailing even-parity bit and offers the word on valid/ready.
module serial_frame_rx #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_i,
  input  logic              bit_vld_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld_o,
  input  logic              data_rdy_i,
  output logic              parity_err_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned         CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [SYNC_W-2:0]   WIN_ZERO = {(SYNC_W-1){1'b0}};
  localparam logic [DATA_W-1:0]   DAT_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_e;

  // True when payload plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

  state_e              state_q, state_d;
  logic [SYNC_W-2:0]   win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic                perr_q, perr_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;

  logic [SYNC_W-1:0]   win_shift_s;
  logic                par_smp_s;
  logic                hs_s;
  logic                par_good_s;

  // Only the youngest SYNC_W-1 bits need storing; the oldest falls out on the next shift.
  assign win_shift_s = {win_q, x_i};
  assign hs_s        = vld_q & data_rdy_i;
  assign par_good_s  = even_parity_ok(shreg_q, x_i);

  // Frame FSM next-state, sync window, bit counter and payload shifter.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_smp_s = 1'b0;
    if (bit_vld_i) begin
      case (state_q)
        ST_HUNT: begin
          win_d = win_shift_s[SYNC_W-2:0];
          if (win_shift_s == SYNC) begin
            state_d = ST_DATA;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_DATA: begin
          shreg_d = {shreg_q[DATA_W-2:0], x_i};
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PAR;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PAR: begin
          par_smp_s = 1'b1;
          state_d   = ST_HUNT;
          win_d     = WIN_ZERO;
        end
        default: begin
          state_d = ST_HUNT;
          win_d   = WIN_ZERO;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output slot: load on good parity if free, otherwise flag the drop.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q & ~hs_s;
    perr_d = 1'b0;
    ovf_d  = 1'b0;
    busy_d = (state_d == ST_DATA) || (state_d == ST_PAR);
    if (par_smp_s) begin
      if (par_good_s) begin
        if (!vld_q || hs_s) begin
          data_d = shreg_q;
          vld_d  = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        perr_d = 1'b1;
      end
    end else begin
      perr_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HUNT;
      win_q   <= WIN_ZERO;
      cnt_q   <= CNT_ZERO;
      shreg_q <= DAT_ZERO;
      data_q  <= DAT_ZERO;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign data_vld_o   = vld_q;
  assign parity_err_o = perr_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: a frame-level reference model queues
// expected words and pulses; a negedge monitor pops and compares.
module tb_serial_frame_rx;

  localparam int         DATA_W = 8;
  localparam int         SYNC_W = 4;
  localparam logic [3:0] SYNC   = 4'b1011;
  localparam byte        EV_P   = 8'h50;
  localparam byte        EV_O   = 8'h4F;

  logic       clk = 1'b0;
  logic       reset, x_i, bit_vld_i, data_rdy_i;
  logic [7:0] data_o;
  logic       data_vld_o, parity_err_o, overflow_o, busy_o;

  serial_frame_rx #(.DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .x_i(x_i), .bit_vld_i(bit_vld_i),
    .data_o(data_o), .data_vld_o(data_vld_o), .data_rdy_i(data_rdy_i),
    .parity_err_o(parity_err_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] exp_data_q[$];
  byte        exp_evt_q[$];

  // Reference model: frames parsed from the sampled bit stream.
  bit         m_hunting = 1'b1;
  bit         m_hist[$];
  bit         m_frame[$];
  bit         m_full = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit         hs;
    int         v, ones;
    logic [7:0] w;
    if (reset) begin
      m_hunting = 1'b1;
      m_hist.delete();
      m_frame.delete();
      m_full = 1'b0;
    end else begin
      hs = m_full && data_rdy_i;
      if (bit_vld_i) begin
        if (m_hunting) begin
          m_hist.push_back(x_i);
          if (m_hist.size() > SYNC_W) void'(m_hist.pop_front());
          if (m_hist.size() == SYNC_W) begin
            v = 0;
            for (int i = 0; i < SYNC_W; i++) v = v * 2 + int'(m_hist[i]);
            if (v == int'(SYNC)) begin
              m_hunting = 1'b0;
              m_frame.delete();
            end
          end
        end else begin
          m_frame.push_back(x_i);
          if (m_frame.size() == DATA_W + 1) begin
            w = 8'h00;
            for (int i = 0; i < DATA_W; i++) w = {w[6:0], m_frame[i]};
            ones = $countones(w) + int'(m_frame[DATA_W]);
            if (ones % 2 == 0) begin
              if (!m_full || hs) begin
                exp_data_q.push_back(w);
                m_full = 1'b1;
                hs = 1'b0;
              end else begin
                exp_evt_q.push_back(EV_O);
              end
            end else begin
              exp_evt_q.push_back(EV_P);
            end
            m_hunting = 1'b1;
            m_hist.delete();
          end
        end
      end
      if (hs) m_full = 1'b0;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      check("busy", busy_o, !m_hunting);
      check("data_vld", data_vld_o, m_full);
      if (prev_hold) check("hold_data", data_o, prev_data);
      if (parity_err_o) begin
        check("parity_err_expected", exp_evt_q.size() > 0, 1);
        if (exp_evt_q.size() > 0) check("parity_err_kind", exp_evt_q.pop_front(), EV_P);
      end
      if (overflow_o) begin
        check("overflow_expected", exp_evt_q.size() > 0, 1);
        if (exp_evt_q.size() > 0) check("overflow_kind", exp_evt_q.pop_front(), EV_O);
      end
      if (data_vld_o && data_rdy_i) begin
        check("word_expected", exp_data_q.size() > 0, 1);
        if (exp_data_q.size() > 0) check("data_word", data_o, exp_data_q.pop_front());
      end
      prev_hold = data_vld_o && !data_rdy_i;
      prev_data = data_o;
    end
  end

  int rdy_mode = 1;  // 0: low, 1: high, 2: random

  task automatic cyc(input logic b, input logic v);
    @(posedge clk);
    #1;
    x_i        = b;
    bit_vld_i  = v;
    data_rdy_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // gap: 0 none, 1 one idle between bits, 2 random 0..2 idles
  task automatic send_bits(input logic [63:0] bits, input int n, input int gap, input int last_rdy);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap == 1) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
      if (i == 0 && last_rdy >= 0) rdy_mode = last_rdy;
      cyc(bits[i], 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] word, input logic flip, input int gap, input int last_rdy);
    logic [12:0] f;
    f = {SYNC, word, (^word) ^ flip};
    send_bits(64'(f), 13, gap, last_rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, data_o, 8'h00);
    check({tag, "_vld"}, data_vld_o, 1'b0);
    check({tag, "_perr"}, parity_err_o, 1'b0);
    check({tag, "_ovf"}, overflow_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    reset = 1'b1; x_i = 1'b0; bit_vld_i = 1'b0; data_rdy_i = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rdy_mode = 1; send_frame(8'hA5, 1'b0, 0, -1); idle(3);
    send_frame(8'hA5, 1'b1, 0, -1); idle(3);
    send_bits(64'b0010110, 7, 0, -1); send_frame(8'h3C, 1'b0, 0, -1); idle(3);

    rdy_mode = 0; send_frame(8'h11, 1'b0, 0, -1); send_frame(8'h22, 1'b0, 0, -1);
    idle(3); rdy_mode = 1; idle(3);

    send_frame(8'hF0, 1'b0, 1, -1); idle(3);

    rdy_mode = 0; send_frame(8'h66, 1'b0, 0, -1); send_frame(8'h99, 1'b0, 0, 1); idle(3);

    // Reset with a held word and a partial frame in flight.
    rdy_mode = 0; send_frame(8'h5A, 1'b0, 0, -1);
    send_bits(64'b1011_1001, 8, 0, -1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    exp_data_q.delete();
    exp_evt_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    rdy_mode = 1; send_frame(8'h81, 1'b0, 0, -1); idle(3);

    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int nn;
      nn = $urandom_range(0, 6);
      send_bits(64'($urandom), nn, 0, -1);
      send_frame(8'($urandom), 1'($urandom_range(0, 5) == 0), $urandom_range(0, 2), -1);
    end
    send_bits(64'h0, 20, 0, -1);
    rdy_mode = 1; idle(6);

    check("data_queue_drained", exp_data_q.size(), 0);
    check("event_queue_drained", exp_evt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
